// File: rtl/int_ctrl_pkg.sv
// int_ctrl_pkg: register offsets, FSM states and source indices for int_ctrl
package int_ctrl_pkg;
  localparam int N_SRC_DEF = 3;
  localparam int SRC_TC0 = 0;
  localparam int SRC_TC1 = 1;
  localparam int SRC_EXT = 2;
  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_MASK   = 3'd1;
  localparam logic [2:0] REG_TRIG   = 3'd2;
  localparam logic [2:0] REG_PEND   = 3'd3;
  localparam logic [2:0] REG_CLAIM  = 3'd4;
  localparam logic [2:0] REG_STATUS = 3'd5;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, SERVICE = 2'd2} state_t;
endpackage

// File: rtl/int_prio_enc.sv
// int_prio_enc: lowest-index-wins priority encoder returning index+1, 0 when nothing requests
module int_prio_enc #(
  parameter int N = 3,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  output logic [IDW-1:0] id
);
  always_comb begin
    id = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[i]) id = IDW'(i + 1);
  end
endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: interrupt controller with pend latching, masking, priority and claim/complete handshake
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int N_SRC = N_SRC_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:2]      Addr,
  input  logic             WE,
  input  logic             RE,
  input  logic [31:0]      Din,
  output logic [31:0]      Dout,
  input  logic [N_SRC-1:0] src,
  output logic             IRQ
);
  localparam int IDW = $clog2(N_SRC + 1);
  logic             ge;
  logic [N_SRC-1:0] mask, trig, pend, src_d, pend_n, pend_clr, eligible, win_oh;
  logic [IDW-1:0]   id, active_id;
  logic [2:0]       ra;
  logic             claim_rd, complete, unused_bits;
  state_t           state, state_n;
  assign ra = Addr[4:2];
  assign unused_bits = ^{Addr[31:5], Din[31:8]};
  assign eligible = pend & mask & {N_SRC{ge}};
  assign win_oh = eligible & (~eligible + N_SRC'(1));
  int_prio_enc #(.N(N_SRC), .IDW(IDW)) u_enc (.req(eligible), .id(id));
  // a read that coincides with a write is a plain read with no claim side effect
  assign claim_rd = RE && !WE && ra == REG_CLAIM && state == WAIT && |eligible;
  assign complete = WE && ra == REG_CLAIM && state == SERVICE && Din[7:0] == 8'(active_id);
  assign pend_clr = ((WE && ra == REG_PEND) ? Din[N_SRC-1:0] : '0) | (claim_rd ? win_oh : '0);
  // edge bits: a new edge beats any clear in the same cycle; level bits follow src
  assign pend_n = (trig & ((pend & ~pend_clr) | (src & ~src_d))) | (~trig & src);
  assign IRQ = state == WAIT;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (|eligible ? WAIT : IDLE)
            : state == WAIT ? (!(|eligible) ? IDLE : claim_rd ? SERVICE : WAIT)
            : (complete ? IDLE : SERVICE);
  end
  always_comb begin
    Dout = '0;
    case (ra)
      REG_CTRL:   Dout = 32'(ge);
      REG_MASK:   Dout = 32'(mask);
      REG_TRIG:   Dout = 32'(trig);
      REG_PEND:   Dout = 32'(pend);
      REG_CLAIM:  Dout = state == WAIT ? 32'(id) : '0;
      REG_STATUS: Dout = (32'(active_id) << 8) | 32'(state);
      default:    Dout = '0;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      ge        <= 1'b0;
      mask      <= '0;
      trig      <= '0;
      pend      <= '0;
      src_d     <= '0;
      active_id <= '0;
    end else begin
      src_d <= src;
      pend  <= pend_n;
      if (WE && ra == REG_CTRL) ge <= Din[0];
      if (WE && ra == REG_MASK) mask <= Din[N_SRC-1:0];
      if (WE && ra == REG_TRIG) trig <= Din[N_SRC-1:0];
      if (claim_rd) active_id <= id;
    end
endmodule

// File: doc/int_ctrl.md
# int_ctrl

Programmable interrupt controller for the MIPS microsystem. It sits behind the Bridge as a word-addressed peripheral, alongside TC0 and TC1. It collects the TC0, TC1 and external interrupt lines, latches them as pending, masks and prioritises them, and drives one registered IRQ line into the CPU. The handler uses a claim/complete handshake, so only one source is in service at a time.

## Interface
Parameters:
- N_SRC, 3: number of interrupt sources. Source 0 is TC0, 1 is TC1, 2 is external. Lower index means higher priority.

Ports:
- clk  input  1  system clock; the only clock.
- reset  input  1  asynchronous, active-high reset.
- Addr  input  30 (Addr[31:2])  word address from the Bridge; Addr[4:2] selects the register.
- WE  input  1  write strobe, valid for one cycle.
- RE  input  1  read strobe, valid for one cycle; needed because CLAIM reads have a side effect.
- Din  input  32  write data.
- Dout  output  32  read data; combinational from Addr.
- src  input  N_SRC  raw interrupt lines, synchronous to clk.
- IRQ  output  1  interrupt request to the CPU.

## Operation
Register map (Addr[4:2]):
- 0 CTRL: bit0 is GE, the global enable.
- 1 MASK: bit i enables source i.
- 2 TRIG: bit i = 1 means rising-edge trigger, 0 means level trigger.
- 3 PEND:
  - Read returns pend.
  - Write-1-to-clear, applied to edge-mode bits only.
- 4 CLAIM:
  - Read returns the claimed id.
  - Write is a complete.
- 5 STATUS, read-only: [1:0] state, [9:8] active_id.
- 6, 7: reserved; read 0, writes ignored.

Source handling:
- Edge-mode pend[i] is set when src[i]=1 and src_d[i]=0, where src_d is a one-cycle delayed copy of src.
- Level-mode pend[i] is the registered value of src[i].
- eligible = pend & MASK, gated by GE.
- Winner is the lowest set index of eligible; id = winner+1, and 0 means none.

State machine (reset state IDLE):
- IDLE → WAIT when eligible≠0.
- WAIT → IDLE when eligible becomes 0 (masked, level dropped, or cleared).
- WAIT → SERVICE on a CLAIM read (RE=1, Addr=4):
  - Dout returns the winner id in that same cycle.
  - active_id is latched at that edge.
  - The winner's pend bit is cleared if it is edge-mode.
- SERVICE → IDLE on a CLAIM write where Din[7:0]==active_id.
  - A mismatched id is ignored and the state stays SERVICE.
- CLAIM read in IDLE or SERVICE returns 0 and changes no state.

IRQ = (state==WAIT). IRQ is never high in SERVICE, so there is no nesting.

Simultaneous events:
- Set beats clear: an edge arriving on the same cycle as a PEND clear or a claim-clear leaves pend[i]=1.
- Register write and state update in the same cycle: the new MASK/GE takes effect in the following cycle's eligibility.
- RE and WE both high: the write is performed, and the read is treated as a plain read without side effect.

## Timing
- Reset (asynchronous, immediate) forces:
  - CTRL, MASK, TRIG, pend, src_d and active_id to 0.
  - state to IDLE and IRQ to 0.
  - Dout, as a result, reads 0 for every address.
- Edge latency: src rises before edge k, pend visible after edge k, IRQ high after edge k+1. That is 2 cycles from the src rising edge to IRQ.
- Level latency is the same 2 cycles. Level deassert drops IRQ 2 cycles after src falls, unless the source was already claimed.
- Claim read at edge k: IRQ low after edge k.
- Complete write at edge k: state is IDLE after edge k. If another source is eligible, IRQ is high again after edge k+1.
- Reset asserted mid-WAIT or mid-SERVICE abandons the handshake. There is no deferred completion.

## Structure
- Shared package/header int_ctrl_pkg holds:
  - register offsets (CTRL=0 … STATUS=5);
  - state encodings IDLE=0, WAIT=1, SERVICE=2;
  - the source indices TC0=0, TC1=1, EXT=2;
  - the default N_SRC.
- One sub-module is natural: int_prio_enc, a combinational lowest-index priority encoder returning id+1, with 0 meaning none.
- Everything else (edge detection, pend, the FSM and the register file) lives in int_ctrl itself.

## Test plan
- **Basic edge path.** GE=1, MASK=3'b111, TRIG=3'b111; pulse src[1] for 1 cycle → IRQ high 2 cycles later. CLAIM read returns 2 and IRQ drops. Complete with 2 → STATUS state=0.
- **Priority.** src[2] and src[0] rise on the same cycle → first claim returns 1. Complete with 1 → IRQ high again after 1 cycle, and the second claim returns 3.
- **Masking and level mode.**
  - TRIG=0, MASK=3'b001, src[0] held high → IRQ stays high until claimed.
  - After claim and complete with src[0] still high → IRQ high again.
  - MASK=0 while in WAIT → IRQ low the next cycle.
- **Handshake errors.** CLAIM read in IDLE → 0, no state change. In SERVICE with active_id=1, complete with 2 → ignored and state stays 2. Complete with 1 → IDLE.
- **Simultaneous events.** Edge on src[0] on the same cycle as a PEND write of 32'h1 → PEND reads 1 afterwards. A new src[0] edge during SERVICE for source 1 → IRQ returns 1 cycle after completion.
- **Reset mid-SERVICE.** Assert reset asynchronously, between edges → IRQ=0, all registers read 0, and state is IDLE immediately, without waiting for a clock edge.
